// File: rtl/score_display.sv
// Score display driver for a 4-digit common-anode 7-segment display.
// Time-multiplexes one digit per REFRESH_DIV clocks, latches all score inputs into shadow
// registers once per frame (no mid-frame tearing) and blinks a player's digits for
// FLASH_TOGGLES blink half-periods whenever that player's scores change.
//
// Ports:
//   clk                 board clock
//   reset               asynchronous active-low reset
//   player1_score       player 1 game score (2 bits)
//   player2_score       player 2 game score (2 bits)
//   player1_match_score player 1 match score (3 bits)
//   player2_match_score player 2 match score (3 bits)
//   hit                 rally hit count (3 bits)
//   squash_switch       squash mode select
//   an                  digit anodes, active-low, an[0] rightmost
//   seg                 segments {g,f,e,d,c,b,a}, active-low
//   dp                  decimal point, active-low
//   flash_active        high while a flash episode is running
module score_display #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned BLINK_DIV     = 25000000,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] player1_score,
  input  logic [1:0] player2_score,
  input  logic [2:0] player1_match_score,
  input  logic [2:0] player2_match_score,
  input  logic [2:0] hit,
  input  logic       squash_switch,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       flash_active
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned TW = $clog2(FLASH_TOGGLES + 1);

  typedef enum logic [0:0] {StShow, StFlash} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [TW-1:0] toggles_q, toggles_d;
  logic [1:0]    mask_q, mask_d;
  logic          phase_q, phase_d;   // 1 = digits visible
  logic          primed_q, primed_d; // a previous frame exists to compare against

  logic [1:0]    sh_p1g_q, sh_p1g_d, sh_p2g_q, sh_p2g_d;
  logic [2:0]    sh_p1m_q, sh_p1m_d, sh_p2m_q, sh_p2m_d, sh_hit_q, sh_hit_d;
  logic          sh_sq_q, sh_sq_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          flash_q, flash_d;

  logic          refresh_tc, frame_start, blink_tc;
  logic          p1_chg, p2_chg, enter_squash;
  logic [3:0]    dval;
  logic          dblank, flash_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Refresh counter, digit index and frame-start shadow capture
  always_comb begin
    refresh_tc  = (refresh_q == RW'(REFRESH_DIV - 1));
    frame_start = refresh_tc && (idx_q == 2'd3);
    refresh_d   = refresh_tc ? '0 : refresh_q + RW'(1);
    idx_d       = refresh_tc ? idx_q + 2'd1 : idx_q;

    sh_p1g_d = sh_p1g_q;
    sh_p2g_d = sh_p2g_q;
    sh_p1m_d = sh_p1m_q;
    sh_p2m_d = sh_p2m_q;
    sh_hit_d = sh_hit_q;
    sh_sq_d  = sh_sq_q;
    primed_d = primed_q;
    if (frame_start) begin
      sh_p1g_d = player1_score;
      sh_p2g_d = player2_score;
      sh_p1m_d = player1_match_score;
      sh_p2m_d = player2_match_score;
      sh_hit_d = hit;
      sh_sq_d  = squash_switch;
      primed_d = 1'b1;
    end

    // The current shadow is the previous frame once the new inputs are latched, so compare
    // the inputs against it directly. Both frames must be in normal mode.
    p1_chg = frame_start && primed_q && !squash_switch && !sh_sq_q &&
             ((player1_score != sh_p1g_q) || (player1_match_score != sh_p1m_q));
    p2_chg = frame_start && primed_q && !squash_switch && !sh_sq_q &&
             ((player2_score != sh_p2g_q) || (player2_match_score != sh_p2m_q));
    enter_squash = frame_start && squash_switch;
  end

  // Flash FSM next-state
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    phase_d   = phase_q;
    blink_d   = blink_q;
    toggles_d = toggles_q;
    blink_tc  = (blink_q == BW'(BLINK_DIV - 1));

    unique case (state_q)
      StShow: begin
        if (p1_chg || p2_chg) begin
          state_d   = StFlash;
          mask_d    = {p1_chg, p2_chg};
          phase_d   = 1'b0;
          blink_d   = '0;
          toggles_d = TW'(FLASH_TOGGLES);
        end
      end
      StFlash: begin
        blink_d = blink_tc ? '0 : blink_q + BW'(1);
        if (blink_tc) begin
          phase_d   = ~phase_q;
          toggles_d = toggles_q - TW'(1);
        end
        if (p1_chg || p2_chg) begin
          // Extend the episode; the blink phase keeps running undisturbed
          mask_d    = mask_q | {p1_chg, p2_chg};
          toggles_d = TW'(FLASH_TOGGLES);
        end else if (blink_tc && (toggles_q == TW'(1))) begin
          state_d = StShow;
          phase_d = 1'b1;
          mask_d  = 2'b00;
          blink_d = '0;
        end
      end
      default: state_d = StShow;
    endcase

    if (enter_squash) begin
      state_d   = StShow;
      mask_d    = 2'b00;
      phase_d   = 1'b1;
      blink_d   = '0;
      toggles_d = '0;
    end
  end

  // Registered display outputs, driven from the current index and shadow contents
  always_comb begin
    dval   = 4'd0;
    dblank = 1'b0;
    dp_d   = 1'b1;
    if (sh_sq_q) begin
      unique case (idx_q)
        2'd0:    dval = {1'b0, sh_hit_q};
        2'd1:    dval = {1'b0, sh_p2m_q};
        default: dblank = 1'b1;
      endcase
    end else begin
      unique case (idx_q)
        2'd3: dval = {1'b0, sh_p1m_q};
        2'd2: begin
          dval = {2'b00, sh_p1g_q};
          dp_d = 1'b0;
        end
        2'd1: dval = {2'b00, sh_p2g_q};
        default: dval = {1'b0, sh_p2m_q};
      endcase
    end
    // Player 1 owns digits 3,2 (mask bit 1); player 2 owns digits 1,0 (mask bit 0)
    flash_blank = !phase_q && (idx_q[1] ? mask_q[1] : mask_q[0]);
    seg_d       = (dblank || flash_blank) ? 7'h7F : seg_decode(dval);
    an_d        = ~(4'b0001 << idx_q);
    flash_d     = (state_q == StFlash);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StShow;
      refresh_q <= '0;
      idx_q     <= 2'd0;
      blink_q   <= '0;
      toggles_q <= '0;
      mask_q    <= 2'b00;
      phase_q   <= 1'b1;
      primed_q  <= 1'b0;
      sh_p1g_q  <= '0;
      sh_p2g_q  <= '0;
      sh_p1m_q  <= '0;
      sh_p2m_q  <= '0;
      sh_hit_q  <= '0;
      sh_sq_q   <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      flash_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      blink_q   <= blink_d;
      toggles_q <= toggles_d;
      mask_q    <= mask_d;
      phase_q   <= phase_d;
      primed_q  <= primed_d;
      sh_p1g_q  <= sh_p1g_d;
      sh_p2g_q  <= sh_p2g_d;
      sh_p1m_q  <= sh_p1m_d;
      sh_p2m_q  <= sh_p2m_d;
      sh_hit_q  <= sh_hit_d;
      sh_sq_q   <= sh_sq_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      flash_q   <= flash_d;
    end
  end

  assign an           = an_q;
  assign seg          = seg_q;
  assign dp           = dp_q;
  assign flash_active = flash_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with small divider parameters.
module tb_score_display;

  localparam int unsigned R  = 4;
  localparam int unsigned B  = 8;
  localparam int unsigned FT = 4;
  localparam int          FRAME = 4 * R;

  localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] p1g, p2g;
  logic [2:0] p1m, p2m, hit;
  logic       sq;
  logic [3:0] an_w;
  logic [6:0] seg_w;
  logic       dp_w, fa_w;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  score_display #(
    .REFRESH_DIV  (R),
    .BLINK_DIV    (B),
    .FLASH_TOGGLES(FT)
  ) dut (
    .clk                (clk),
    .reset              (rst_n),
    .player1_score      (p1g),
    .player2_score      (p2g),
    .player1_match_score(p1m),
    .player2_match_score(p2m),
    .hit                (hit),
    .squash_switch      (sq),
    .an                 (an_w),
    .seg                (seg_w),
    .dp                 (dp_w),
    .flash_active       (fa_w)
  );

  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected {an, seg, dp} for a digit index given the shadow contents and blink state
  function automatic logic [11:0] disp(input int idx, input int s1g, input int s1m,
                                       input int s2g, input int s2m, input int sh,
                                       input bit ssq, input bit off, input logic [1:0] msk);
    logic [6:0] s;
    logic       d;
    int         v;
    bit         blank;
    logic [3:0] a;
    d = 1'b1; blank = 1'b0; v = 0;
    if (ssq) begin
      if (idx == 0) v = sh;
      else if (idx == 1) v = s2m;
      else blank = 1'b1;
    end else begin
      case (idx)
        3: v = s1m;
        2: begin v = s1g; d = 1'b0; end
        1: v = s2g;
        default: v = s2m;
      endcase
    end
    if (off && ((idx >= 2) ? msk[1] : msk[0])) blank = 1'b1;
    s = blank ? 7'h7F : SEG_TAB[v];
    a = 4'b1111;
    a[idx] = 1'b0;
    return {a, s, d};
  endfunction

  // Behavioural model: time-based view of frames and blink episodes
  int         m_n, m_origin, m_tog;
  int         s_p1g, s_p1m, s_p2g, s_p2m, s_hit;
  bit         s_sq, m_primed, m_flash;
  logic [1:0] m_mask;
  logic [11:0] cur, pend;
  logic        cur_fa, pend_fa;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0; m_origin = 0; m_tog = 0; m_mask = 2'b00;
        s_p1g = 0; s_p1m = 0; s_p2g = 0; s_p2m = 0; s_hit = 0; s_sq = 1'b0;
        m_primed = 1'b0; m_flash = 1'b0;
        cur = {4'hF, 7'h7F, 1'b1}; cur_fa = 1'b0;
        pend = disp(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00); pend_fa = 1'b0;
      end else begin
        bit fs, c1, c2, off;
        cur = pend; cur_fa = pend_fa;
        fs = (m_n % FRAME) == FRAME - 1;
        if (m_flash && m_n > m_origin && ((m_n - m_origin) % B) == 0) m_tog--;
        c1 = 1'b0; c2 = 1'b0;
        if (fs && m_primed && !sq && !s_sq) begin
          c1 = (int'(p1g) != s_p1g) || (int'(p1m) != s_p1m);
          c2 = (int'(p2g) != s_p2g) || (int'(p2m) != s_p2m);
        end
        if (c1 || c2) begin
          if (!m_flash) begin m_flash = 1'b1; m_origin = m_n; end
          m_mask = m_mask | {c1, c2};
          m_tog = FT;
        end else if (m_flash && m_tog == 0) begin
          m_flash = 1'b0; m_mask = 2'b00;
        end
        if (fs && sq) begin m_flash = 1'b0; m_mask = 2'b00; end
        if (fs) begin
          s_p1g = int'(p1g); s_p1m = int'(p1m); s_p2g = int'(p2g); s_p2m = int'(p2m);
          s_hit = int'(hit); s_sq = sq; m_primed = 1'b1;
        end
        // Blink starts dark and alternates every B clocks from entry
        off = m_flash && ((((m_n - m_origin) / B) % 2) == 0);
        pend = disp(((m_n + 1) / R) % 4, s_p1g, s_p1m, s_p2g, s_p2m, s_hit, s_sq, off, m_mask);
        pend_fa = m_flash;
        m_n++;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("an", {8'h0, an_w}, {8'h0, cur[11:8]});
        check("seg", {5'h0, seg_w}, {5'h0, cur[7:1]});
        check("dp", {11'h0, dp_w}, {11'h0, cur[0]});
        check("flash_active", {11'h0, fa_w}, {11'h0, cur_fa});
      end
    end
  end

  task automatic nclk(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v);
    int k;
    k = 0;
    while (an_w !== v && k < 40) begin @(negedge clk); k++; end
    check("wait_an", {8'h0, an_w}, {8'h0, v});
  endtask

  task automatic wait_flash();
    int k;
    k = 0;
    while (fa_w !== 1'b1 && k < 80) begin @(negedge clk); k++; end
    check("wait_flash", {11'h0, fa_w}, 12'h001);
  endtask

  initial begin
    int seen;
    p1g = '0; p2g = '0; p1m = '0; p2m = '0; hit = '0; sq = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #2;
    check("reset_an", {8'h0, an_w}, 12'h00F);
    check("reset_seg", {5'h0, seg_w}, 12'h07F);
    check("reset_fa", {11'h0, fa_w}, 12'h000);
    nclk(2);
    rst_n = 1'b1;

    // Edge counts below are numbered from the first rising edge after release (edge 0)
    nclk(1);                                         // edge 0
    check("e0_an", {8'h0, an_w}, 12'h00E);
    check("e0_seg", {5'h0, seg_w}, 12'h040);
    nclk(8);                                         // edge 8
    check("e8_an", {8'h0, an_w}, 12'h00B);
    check("e8_dp", {11'h0, dp_w}, 12'h000);
    nclk(12);                                        // edge 20
    p1m = 3'd3; p2g = 2'd1;                          // sampled at frame start, edge 31
    nclk(12);                                        // edge 32
    check("e32_fa", {11'h0, fa_w}, 12'h001);
    check("e32_seg_blank", {5'h0, seg_w}, 12'h07F);
    nclk(12);                                        // edge 44
    check("e44_an", {8'h0, an_w}, 12'h007);
    check("e44_seg_p1m3", {5'h0, seg_w}, 12'h030);
    nclk(19);                                        // edge 63
    check("e63_fa", {11'h0, fa_w}, 12'h001);
    nclk(1);                                         // edge 64
    check("e64_fa", {11'h0, fa_w}, 12'h000);
    nclk(4);                                         // edge 68
    check("e68_an", {8'h0, an_w}, 12'h00D);
    check("e68_seg_p2g1", {5'h0, seg_w}, 12'h079);

    // Mid-frame change of player 2 only
    nclk(5);
    p2g = 2'd2;
    nclk(3 * FRAME);

    // Squash mode
    sq = 1'b1; hit = 3'd5; p2m = 3'd2;
    nclk(2 * FRAME);
    wait_an(4'b1110);
    check("sq_d0_seg", {5'h0, seg_w}, 12'h012);
    check("sq_d0_dp", {11'h0, dp_w}, 12'h001);
    wait_an(4'b1101);
    check("sq_d1_seg", {5'h0, seg_w}, 12'h024);
    wait_an(4'b0111);
    check("sq_d3_seg", {5'h0, seg_w}, 12'h07F);
    sq = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (fa_w) seen++;
    end
    check("mode_back_no_flash", 12'(seen), 12'h000);

    // Player 2 change, then a player 1 change while flashing, then reset mid-flash
    p2m = 3'd4;
    wait_flash();
    nclk(FRAME);
    p1g = 2'd3;
    nclk(FRAME + 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", {8'h0, an_w}, 12'h00F);
    check("async_seg", {5'h0, seg_w}, 12'h07F);
    check("async_fa", {11'h0, fa_w}, 12'h000);
    nclk(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (fa_w) seen++;
    end
    check("post_reset_no_flash", 12'(seen), 12'h000);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0: p1g = 2'($urandom_range(0, 3));
          1: p2g = 2'($urandom_range(0, 3));
          2: p1m = 3'($urandom_range(0, 7));
          3: p2m = 3'($urandom_range(0, 7));
          default: hit = 3'($urandom_range(0, 7));
        endcase
      end
      if ($urandom_range(0, 199) == 0) sq = ~sq;
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
